// File: rtl/axi_tile_scatter.sv
// AXI R-beat to bank-array scatter unit for tensor-core A/B/C tile loads.
// Optional checker build: define AXI_TILE_SCATTER_CHK_EN to add the err/err_code outputs.
package params;
  typedef enum logic [1:0] {MAT_A = 2'd0, MAT_B = 2'd1, MAT_C = 2'd2} mat_t;
  typedef enum logic [1:0] {T_FP32 = 2'd0, T_FP16 = 2'd1, T_INT8 = 2'd2, T_INT4 = 2'd3} type_t;
endpackage

// state | meaning
// IDLE  | waiting for cfg_start, cfg_* sampled here only
// RUN   | accepting beats until cnt reaches the latched length
// DRAIN | last beat accepted, waiting for the output register to empty
module axi_tile_scatter #(
  parameter int DATA_W    = 256,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int BANK_W    = 32,
  parameter int ACC_W     = 32,
  parameter int MAX_BEATS = 64,
  localparam int RW       = $clog2(ROWS),
  localparam int CW       = $clog2(MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  params::mat_t            cfg_mat,
  input  params::type_t           cfg_type,
  input  logic [1:0]              cfg_rc,
  input  logic                    cfg_mixed,
  input  logic [CW-1:0]           cfg_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output params::mat_t            m_mat,
  output logic [ROWS*COLS-1:0]    m_we,
  output logic [COLS*ACC_W-1:0]   m_data,
  output logic                    busy,
  output logic                    done
`ifdef AXI_TILE_SCATTER_CHK_EN
  ,
  output logic                    err,
  output logic [1:0]              err_code
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       len_q;
  params::type_t       type_q;
  logic [1:0]          rc_q;
  logic                mixed_q;

  logic                out_free;
  logic                accept;
  logic                last_beat;
  logic [31:0]         sh32;
  logic [RW-1:0]       row;
  logic [ROWS*COLS-1:0] we_nxt;
  logic [COLS*ACC_W-1:0] data_nxt;

  assign out_free  = !m_valid || m_ready;
  assign s_ready   = (state == RUN) && out_free;
  assign accept    = s_valid && s_ready;
  assign last_beat = (cnt == len_q);
  assign busy      = (state != IDLE);

  // Shape 11 is not a legal tile shape and falls back to M32N8 row stepping.
  always_comb begin
    case (rc_q)
      2'b01:   sh32 = 32'(cnt) >> 1;
      2'b10:   sh32 = 32'(cnt) >> 2;
      default: sh32 = 32'(cnt);
    endcase
    row = RW'(sh32 % 32'(ROWS));
  end

  always_comb begin
    we_nxt = '0;
    we_nxt[row*COLS +: COLS] = '1;
  end

  always_comb begin
    data_nxt = '0;
    for (int c = 0; c < COLS; c++) begin
      if (m_mat != params::MAT_C) begin
        data_nxt[c*ACC_W +: ACC_W] = ACC_W'(s_data[c*BANK_W +: BANK_W]);
      end else begin
        case (type_q)
          params::T_FP32:
            data_nxt[c*ACC_W +: ACC_W] = ACC_W'(s_data[c*32 +: 32]);
          params::T_FP16:
            // Mixed precision keeps C in FP32, so lanes are taken as 32-bit raw words.
            if (mixed_q)
              data_nxt[c*ACC_W +: ACC_W] = ACC_W'(s_data[c*32 +: 32]);
            else
              data_nxt[c*ACC_W +: ACC_W] = ACC_W'(s_data[c*16 +: 16]);
          params::T_INT8:
            data_nxt[c*ACC_W +: ACC_W] = {{(ACC_W-8){s_data[c*8+7]}}, s_data[c*8 +: 8]};
          default:
            data_nxt[c*ACC_W +: ACC_W] = {{(ACC_W-4){s_data[c*4+3]}}, s_data[c*4 +: 4]};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      m_mat   <= params::MAT_A;
      type_q  <= params::T_FP32;
      rc_q    <= 2'b00;
      mixed_q <= 1'b0;
      m_valid <= 1'b0;
      m_we    <= '0;
      m_data  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            m_mat   <= cfg_mat;
            type_q  <= cfg_type;
            rc_q    <= cfg_rc;
            mixed_q <= cfg_mixed;
            len_q   <= cfg_len;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_free) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        m_valid <= 1'b1;
        m_we    <= we_nxt;
        m_data  <= data_nxt;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_we    <= '0;
      end
    end
  end

`ifdef AXI_TILE_SCATTER_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (state == IDLE && cfg_start) begin
      err      <= (cfg_rc == 2'b11);
      err_code <= (cfg_rc == 2'b11) ? 2'b10 : 2'b00;
    end else if (!err) begin
      if (accept && (s_last != last_beat)) begin
        err      <= 1'b1;
        err_code <= 2'b01;
      end else if (busy && cfg_start) begin
        err      <= 1'b1;
        err_code <= 2'b11;
      end
    end
  end
`else
  // RLAST carries no information here; transfer length comes from cfg_len alone.
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

endmodule
